// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory access sequencer: FSM state
// encoding, alignment mask, wait-counter width and an alignment helper.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } mem_state_t;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  // Width of the shared wait counter (latencies 1..15 load 0..14).
  localparam int LAT_W = 4;

  // True when a byte address is not on a 32-bit word boundary.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return ((addr[1:0] & WORD_ALIGN_MASK) != 2'b00);
  endfunction

endpackage

// File: rtl/latency_counter.sv
// Down-counter shared by the read and write wait states. It is loaded with
// (latency - 1) when a request is accepted, counts down while the FSM waits,
// and reports zero on the cycle the access completes.
module latency_counter
  import mips_mem_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         Clk,
  input  logic         Reset_signal,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Count register: reset, load on accept, otherwise saturating decrement.
  always_ff @(posedge Clk) begin
    if (Reset_signal) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle memory access sequencer. Accepts one read or write request at a
// time from the control FSM, drives the unified memory port for a fixed
// latency and returns a single-cycle response pulse. Misaligned addresses are
// answered with an error response without touching memory.
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Reset_signal,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  // Counter load values: the access completes on the edge where the
  // counter reads zero, so a latency of N loads N-1.
  localparam logic [LAT_W-1:0] RD_LOAD = LAT_W'(READ_LATENCY - 1);
  localparam logic [LAT_W-1:0] WR_LOAD = LAT_W'(WRITE_LATENCY - 1);

  mem_state_t       state_r;
  logic             misaligned_s;
  logic             accept_s;
  logic             cnt_load_s;
  logic [LAT_W-1:0] cnt_load_val_s;
  logic             cnt_dec_s;
  logic             cnt_zero_s;

  assign misaligned_s = is_misaligned(req_addr);
  assign accept_s     = (state_r == IDLE) && req_valid;

  // Counter control: load on an aligned accept, count down while waiting.
  always_comb begin
    cnt_load_s     = 1'b0;
    cnt_load_val_s = RD_LOAD;
    cnt_dec_s      = 1'b0;
    if (accept_s && !misaligned_s) begin
      cnt_load_s = 1'b1;
      if (req_wr) begin
        cnt_load_val_s = WR_LOAD;
      end else begin
        cnt_load_val_s = RD_LOAD;
      end
    end else begin
      cnt_load_s = 1'b0;
    end
    if ((state_r == RD_WAIT) || (state_r == WR_WAIT)) begin
      cnt_dec_s = 1'b1;
    end else begin
      cnt_dec_s = 1'b0;
    end
  end

  latency_counter #(
    .W(LAT_W)
  ) u_latency_counter (
    .Clk          (Clk),
    .Reset_signal (Reset_signal),
    .load         (cnt_load_s),
    .load_val     (cnt_load_val_s),
    .dec          (cnt_dec_s),
    .zero         (cnt_zero_s)
  );

  // Sequencer FSM together with the registered memory and response fields.
  always_ff @(posedge Clk) begin
    if (Reset_signal) begin
      state_r    <= IDLE;
      mem_addr   <= 32'h0000_0000;
      mem_wdata  <= 32'h0000_0000;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            if (misaligned_s) begin
              // Answer with an error; memory port registers stay untouched.
              resp_err <= 1'b1;
              state_r  <= RESP;
            end else if (req_wr) begin
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
              state_r   <= WR_WAIT;
            end else begin
              mem_addr <= req_addr;
              state_r  <= RD_WAIT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD_WAIT: begin
          if (cnt_zero_s) begin
            resp_rdata <= mem_rdata;
            resp_err   <= 1'b0;
            state_r    <= RESP;
          end else begin
            state_r <= RD_WAIT;
          end
        end
        WR_WAIT: begin
          if (cnt_zero_s) begin
            resp_err <= 1'b0;
            state_r  <= RESP;
          end else begin
            state_r <= WR_WAIT;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Handshake and strobe outputs are pure decodes of the state register.
  assign req_ready  = (state_r == IDLE);
  assign busy       = (state_r != IDLE);
  assign resp_valid = (state_r == RESP);
  assign mem_wr     = (state_r == WR_WAIT);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a vector table of single requests on a
// default-latency instance, plus hand-written sequences for queued requests
// and for reset during a long write on a WRITE_LATENCY=3 instance.
module tb_mem_access_ctrl;

  logic        Clk;
  logic        Reset_signal, req_valid, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, busy, mem_wr;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        Reset3, req_valid3, req_wr3;
  logic [31:0] req_addr3, req_wdata3;
  logic        req_ready3, resp_valid3, resp_err3, busy3, mem_wr3;
  logic [31:0] resp_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl dut (
    .Clk(Clk), .Reset_signal(Reset_signal), .req_valid(req_valid),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .busy(busy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  mem_access_ctrl #(.READ_LATENCY(2), .WRITE_LATENCY(3)) dut3 (
    .Clk(Clk), .Reset_signal(Reset3), .req_valid(req_valid3),
    .req_wr(req_wr3), .req_addr(req_addr3), .req_wdata(req_wdata3),
    .req_ready(req_ready3), .resp_valid(resp_valid3), .resp_err(resp_err3),
    .resp_rdata(resp_rdata3), .busy(busy3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_wr(mem_wr3), .mem_rdata(mem_rdata3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory model for the main instance: 64 words, combinational read.
  logic [31:0] mem_arr [0:63];
  assign mem_rdata = mem_arr[mem_addr[7:2]];
  always @(posedge Clk) begin
    if (Reset_signal) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= 32'hA000_0000 | 32'(i);
      mem_arr[4] <= 32'hDEAD_BEEF;
    end else if (mem_wr) begin
      mem_arr[mem_addr[7:2]] <= mem_wdata;
    end
  end

  // Second instance sees an address-derived read pattern.
  assign mem_rdata3 = mem_addr3 ^ 32'h0F0F_0F0F;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          wrc;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } vec_t;

  vec_t vecs [10];

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int wrc;
    bit seen;
    @(negedge Clk);
    chk($sformatf("v%0d_ready", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge Clk); #1;
    req_valid = 1'b0; req_wr = ~v.wr; req_addr = 32'hFFFF_FFF0; req_wdata = 32'h0BAD_0BAD;
    lat = 0; wrc = 0; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (mem_wr) begin
        wrc++;
        chk($sformatf("v%0d_wr_addr", idx), mem_addr, v.maddr);
        chk($sformatf("v%0d_wr_data", idx), mem_wdata, v.mwdata);
      end
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge Clk); #1;
      lat++;
    end
    chk($sformatf("v%0d_resp_seen", idx), {31'd0, seen}, 32'd1);
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_wr_cycles", idx), 32'(wrc), 32'(v.wrc));
    chk($sformatf("v%0d_err", idx), {31'd0, resp_err}, {31'd0, v.err});
    chk($sformatf("v%0d_rdata", idx), resp_rdata, v.rdata);
    chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.maddr);
    chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.mwdata);
    chk($sformatf("v%0d_busy_resp", idx), {31'd0, busy}, 32'd1);
    @(posedge Clk); #1;
    chk($sformatf("v%0d_pulse_end", idx), {31'd0, resp_valid}, 32'd0);
    chk($sformatf("v%0d_idle_ready", idx), {30'd0, req_ready, busy}, 32'd2);
  endtask

  initial begin
    int accepts, nresp, lat, wrc, quiet;
    int t_resp [3];
    bit seen;

    vecs[0] = '{1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0, 32'h10, 32'h0};
    vecs[1] = '{1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF, 1, 1, 32'h20, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h20, 32'h0, 1'b0, 32'h1234_5678, 2, 0, 32'h20, 32'h1234_5678};
    vecs[3] = '{1'b0, 32'h13, 32'h0, 1'b1, 32'h1234_5678, 0, 0, 32'h20, 32'h1234_5678};
    vecs[4] = '{1'b1, 32'h22, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 0, 0, 32'h20, 32'h1234_5678};
    vecs[5] = '{1'b0, 32'h24, 32'h0, 1'b0, 32'hA000_0009, 2, 0, 32'h24, 32'h1234_5678};
    vecs[6] = '{1'b1, 32'hFC, 32'hCAFE_F00D, 1'b0, 32'hA000_0009, 1, 1, 32'hFC, 32'hCAFE_F00D};
    vecs[7] = '{1'b0, 32'hFC, 32'h0, 1'b0, 32'hCAFE_F00D, 2, 0, 32'hFC, 32'hCAFE_F00D};
    vecs[8] = '{1'b0, 32'h11, 32'h0, 1'b1, 32'hCAFE_F00D, 0, 0, 32'hFC, 32'hCAFE_F00D};
    vecs[9] = '{1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0, 32'h10, 32'hCAFE_F00D};

    Reset_signal = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    Reset3 = 1'b1; req_valid3 = 1'b0; req_wr3 = 1'b0; req_addr3 = 32'h0; req_wdata3 = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    @(negedge Clk);
    Reset_signal = 1'b0; Reset3 = 1'b0;
    @(posedge Clk); #1;
    chk("post_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Request held high across three reads: accepted only from IDLE.
    accepts = 0; nresp = 0;
    @(negedge Clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10;
    for (int t = 0; t < 40; t++) begin
      if (req_valid && req_ready) accepts++;
      @(posedge Clk); #1;
      if (accepts == 3) req_valid = 1'b0;
      if (resp_valid) begin
        if (nresp < 3) t_resp[nresp] = t;
        nresp++;
        chk("queue_rdata", resp_rdata, 32'hDEAD_BEEF);
      end
      @(negedge Clk);
    end
    req_valid = 1'b0;
    chk("queue_resp_count", 32'(nresp), 32'd3);
    if (nresp >= 3) begin
      chk("queue_gap1", 32'(t_resp[1] - t_resp[0]), 32'd4);
      chk("queue_gap2", 32'(t_resp[2] - t_resp[1]), 32'd4);
    end

    // Reset in the middle of a three-cycle write on the second instance.
    @(negedge Clk);
    req_valid3 = 1'b1; req_wr3 = 1'b1; req_addr3 = 32'h40; req_wdata3 = 32'h55AA_55AA;
    @(posedge Clk); #1;
    req_valid3 = 1'b0;
    chk("w3_mem_wr_c0", {31'd0, mem_wr3}, 32'd1);
    chk("w3_mem_addr", mem_addr3, 32'h40);
    @(posedge Clk); #1;
    chk("w3_mem_wr_c1", {31'd0, mem_wr3}, 32'd1);
    @(negedge Clk);
    Reset3 = 1'b1;
    @(posedge Clk); #1;
    chk("w3_rst_mem_wr", {31'd0, mem_wr3}, 32'd0);
    chk("w3_rst_busy", {31'd0, busy3}, 32'd0);
    chk("w3_rst_ready", {31'd0, req_ready3}, 32'd1);
    chk("w3_rst_mem_addr", mem_addr3, 32'h0);
    chk("w3_rst_mem_wdata", mem_wdata3, 32'h0);
    @(negedge Clk);
    Reset3 = 1'b0;
    quiet = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk); #1;
      if (resp_valid3 || mem_wr3) quiet++;
    end
    chk("w3_no_resp_after_rst", 32'(quiet), 32'd0);

    // Following write completes with the full three-cycle strobe.
    @(negedge Clk);
    req_valid3 = 1'b1; req_wr3 = 1'b1; req_addr3 = 32'h44; req_wdata3 = 32'h1122_3344;
    @(posedge Clk); #1;
    req_valid3 = 1'b0; req_addr3 = 32'h0; req_wdata3 = 32'h0;
    lat = 0; wrc = 0; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (mem_wr3) wrc++;
      if (resp_valid3) begin
        seen = 1'b1;
        break;
      end
      @(posedge Clk); #1;
      lat++;
    end
    chk("w3b_seen", {31'd0, seen}, 32'd1);
    chk("w3b_latency", 32'(lat), 32'd3);
    chk("w3b_wr_cycles", 32'(wrc), 32'd3);
    chk("w3b_err", {31'd0, resp_err3}, 32'd0);
    chk("w3b_mem_addr", mem_addr3, 32'h44);
    chk("w3b_mem_wdata", mem_wdata3, 32'h1122_3344);

    // Read on the second instance returns the address-derived pattern.
    @(posedge Clk);
    @(negedge Clk);
    req_valid3 = 1'b1; req_wr3 = 1'b0; req_addr3 = 32'h48;
    @(posedge Clk); #1;
    req_valid3 = 1'b0;
    lat = 0; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid3) begin
        seen = 1'b1;
        break;
      end
      @(posedge Clk); #1;
      lat++;
    end
    chk("r3_seen", {31'd0, seen}, 32'd1);
    chk("r3_latency", 32'(lat), 32'd2);
    chk("r3_rdata", resp_rdata3, 32'h0F0F_0F47);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multicycle memory access sequencer between the MIPS control FSM and the unified instruction/data memory.
- Control issues one read (fetch/LW) or write (SW) request; this block drives the memory port for a fixed, parameterised latency and returns a one-cycle response pulse.
- Lets the control FSM wait on resp_valid instead of hard-coding memory-delay states.
- Also flags word-misaligned addresses without touching memory.

Parameters:
- READ_LATENCY, 2, cycles from address presentation to valid mem_rdata (legal range 1..15).
- WRITE_LATENCY, 1, cycles mem_wr is held high per write (legal range 1..15).

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset_signal  in  1  synchronous, active-high reset.
- req_valid  in  1  request strobe; accepted only when req_ready=1.
- req_wr  in  1  1=write, 0=read; sampled on accept.
- req_addr  in  32  byte address; sampled on accept.
- req_wdata  in  32  write data; sampled on accept.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; 1 = misaligned, no access performed.
- resp_rdata  out  32  read data; updated only on a successful read response; otherwise holds.
- busy  out  1  high in any state other than IDLE.
- mem_addr  out  32  registered memory address; holds the last accepted aligned address.
- mem_wdata  out  32  registered write data.
- mem_wr  out  1  memory write enable; decoded from state, high only in WR_WAIT.
- mem_rdata  in  32  memory read data.

Behaviour:
- States: IDLE, RD_WAIT, WR_WAIT, RESP. The state register, wait counter, mem_addr, mem_wdata, resp_rdata and resp_err are all registered.
- Reset (synchronous, any state, including mid-operation): state=IDLE, counter=0, mem_addr=0, mem_wdata=0, resp_rdata=0, resp_err=0.
  - Resulting outputs: req_ready=1, busy=0, resp_valid=0, mem_wr=0.
  - An in-flight request is dropped; no response is issued.
- Accept: at a rising edge in IDLE with req_valid=1.
  - Aligned read (req_addr[1:0]==0, req_wr=0): mem_addr<=req_addr, counter<=READ_LATENCY-1, go to RD_WAIT.
  - Aligned write: mem_addr<=req_addr, mem_wdata<=req_wdata, counter<=WRITE_LATENCY-1, go to WR_WAIT.
  - Misaligned (req_addr[1:0]!=0): go directly to RESP with resp_err<=1. mem_addr, mem_wdata and mem_wr are untouched.
- RD_WAIT: counter decrements each cycle.
  - At the edge where counter==0: resp_rdata<=mem_rdata, resp_err<=0, go to RESP.
  - Read latency: accept edge k gives resp_valid high in cycle [k+READ_LATENCY, k+READ_LATENCY+1).
- WR_WAIT: mem_wr=1 for exactly WRITE_LATENCY cycles.
  - At counter==0: resp_err<=0, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE unconditionally.
- req_ready=0 throughout RESP, so back-to-back requests are spaced by at least one IDLE cycle.
- req_valid outside IDLE is ignored: no queueing, and no effect on the in-flight request.
- req_* signals may change after accept without effect.
- mem_wr is never high outside WR_WAIT, including the cycle after reset and during misaligned handling.
- Counter width: 4 bits; no wrap in legal parameter range.

Decomposition:
- Shared package mips_mem_pkg:
  - state enum mem_state_t (IDLE, RD_WAIT, WR_WAIT, RESP);
  - localparam WORD_ALIGN_MASK = 2'b11;
  - localparam LAT_W = 4.
- One natural sub-module, latency_counter (load value, decrement, zero flag, synchronous reset), instantiated once and shared by the read and write paths.

Test Plan:
- Reset then idle: assert Reset_signal for 2 cycles → req_ready=1, busy=0, resp_valid=0, mem_wr=0, resp_rdata=0.
- Aligned read at addr 0x00000010, mem model returns 0xDEADBEEF after 2 cycles → mem_addr=0x10 from edge k+1; resp_valid high exactly in cycle k+2, resp_rdata=0xDEADBEEF, resp_err=0.
- Aligned write at addr 0x20, data 0x12345678 → mem_wr high for exactly 1 cycle with mem_addr=0x20, mem_wdata=0x12345678; resp_valid high the next cycle, resp_rdata unchanged.
- Misaligned read at 0x00000013 → mem_wr stays 0, mem_addr unchanged; resp_valid pulse one cycle after accept with resp_err=1.
- req_valid held high continuously with 3 queued reads → each accepted only in IDLE; exactly 3 resp_valid pulses, spaced READ_LATENCY+2 cycles apart.
- Reset asserted during WR_WAIT with WRITE_LATENCY=3 → mem_wr low from the next edge, no resp_valid ever issued; next request completes normally.
